// File: rtl/multi_clock_divider_if.sv
// Config write port of multi_clock_divider: valid/ready handshake carrying
// a target channel and a new division ratio.
interface multi_clock_divider_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned RATIO_W = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               cfgValid;
  logic               cfgReady;
  logic [CH_W-1:0]    cfgChannel;
  logic [RATIO_W-1:0] cfgRatio;

  modport master (output cfgValid, output cfgChannel, output cfgRatio, input cfgReady);
  modport slave  (input cfgValid, input cfgChannel, input cfgRatio, output cfgReady);
endinterface

// File: rtl/multi_clock_divider.sv
// NUM_CH runtime-programmable clock dividers with shadowed ratio updates.
// Define CLKDIV_SYNC_EN to add the syncRestart phase-alignment input.
module multi_clock_divider #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned RATIO_W     = 16,
  parameter int unsigned RESET_RATIO = 100
) (
  input  logic                 sourceClock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    enable,
`ifdef CLKDIV_SYNC_EN
  input  logic                 syncRestart,
`endif
  multi_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]    slowClock,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    pending
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q   [NUM_CH];
  logic [0:0]         state_d   [NUM_CH];
  logic [RATIO_W-1:0] count_q   [NUM_CH];
  logic [RATIO_W-1:0] count_d   [NUM_CH];
  logic [RATIO_W-1:0] active_q  [NUM_CH];
  logic [RATIO_W-1:0] active_d  [NUM_CH];
  logic [RATIO_W-1:0] shadow_q  [NUM_CH];
  logic [RATIO_W-1:0] shadow_d  [NUM_CH];
  logic [NUM_CH-1:0]  slow_q, slow_d;
  logic [NUM_CH-1:0]  tick_q, tick_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;

  logic               sync_w;
  logic               ready_w;
  logic               acc;
  logic               wrap;
  logic [RATIO_W-1:0] next_r;
  logic [RATIO_W-1:0] cnt_inc;
  logic [RATIO_W:0]   hi;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = syncRestart;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range channels match no index and stay ready, so their writes drop.
  always_comb begin
    ready_w = 1'b1;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (cfg.cfgChannel == CH_W'(c)) ready_w = ~pending_q[c];
    end
  end
  assign cfg.cfgReady = ready_w;

  always_comb begin
    acc     = 1'b0;
    wrap    = 1'b0;
    next_r  = '0;
    cnt_inc = '0;
    hi      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c]   = state_q[c];
      count_d[c]   = count_q[c];
      active_d[c]  = active_q[c];
      shadow_d[c]  = shadow_q[c];
      slow_d[c]    = slow_q[c];
      tick_d[c]    = tick_q[c];
      pending_d[c] = pending_q[c];

      acc     = cfg.cfgValid && ready_w && (cfg.cfgChannel == CH_W'(c));
      wrap    = (count_q[c] == active_q[c] - RATIO_W'(1));
      next_r  = pending_q[c] ? shadow_q[c] : active_q[c];
      cnt_inc = count_q[c] + RATIO_W'(1);
      hi      = ({1'b0, active_q[c]} + (RATIO_W+1)'(1)) >> 1;

      if (sync_w && enable[c] && (active_q[c] != '0)) begin
        state_d[c] = ST_RUN;
        count_d[c] = '0;
        slow_d[c]  = 1'b1;
        tick_d[c]  = 1'b1;
        if (pending_q[c]) begin
          active_d[c]  = shadow_q[c];
          pending_d[c] = 1'b0;
        end
      end else if (state_q[c] == ST_IDLE) begin
        count_d[c] = '0;
        slow_d[c]  = 1'b0;
        tick_d[c]  = 1'b0;
        if (pending_q[c]) begin
          active_d[c]  = shadow_q[c];
          pending_d[c] = 1'b0;
        end
        // Start decision uses the ratio in force before this edge.
        if (enable[c] && (active_q[c] != '0)) begin
          state_d[c] = ST_RUN;
          slow_d[c]  = 1'b1;
          tick_d[c]  = 1'b1;
        end
      end else begin
        if (wrap && pending_q[c]) begin
          active_d[c]  = shadow_q[c];
          pending_d[c] = 1'b0;
        end
        if (!enable[c] || (active_q[c] == '0) || (wrap && (next_r == '0))) begin
          state_d[c] = ST_IDLE;
          count_d[c] = '0;
          slow_d[c]  = 1'b0;
          tick_d[c]  = 1'b0;
        end else if (wrap) begin
          count_d[c] = '0;
          slow_d[c]  = 1'b1;
          tick_d[c]  = 1'b1;
        end else begin
          count_d[c] = cnt_inc;
          slow_d[c]  = ({1'b0, cnt_inc} < hi);
          tick_d[c]  = 1'b0;
        end
      end

      // Accept only happens with pending clear, so it never collides with an apply.
      if (acc) begin
        shadow_d[c]  = cfg.cfgRatio;
        pending_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge sourceClock or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]  <= ST_IDLE;
        count_q[c]  <= '0;
        active_q[c] <= RATIO_W'(RESET_RATIO);
        shadow_q[c] <= RATIO_W'(RESET_RATIO);
      end
      slow_q    <= '0;
      tick_q    <= '0;
      pending_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]  <= state_d[c];
        count_q[c]  <= count_d[c];
        active_q[c] <= active_d[c];
        shadow_q[c] <= shadow_d[c];
      end
      slow_q    <= slow_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign slowClock = slow_q;
  assign tick      = tick_q;
  assign pending   = pending_q;
endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider with three channels,
// so that cfgChannel=3 exercises the out-of-range write path.
module tb_multi_clock_divider;
  localparam int unsigned NCH = 3;
  localparam int unsigned RW  = 16;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] enable;
  logic           sync;
  logic [NCH-1:0] slowClock;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  int errors;
  int checks;

  multi_clock_divider_if #(.NUM_CH(NCH), .RATIO_W(RW)) cfg_if ();

  multi_clock_divider #(.NUM_CH(NCH), .RATIO_W(RW), .RESET_RATIO(100)) dut (
    .sourceClock (clk),
    .reset       (rst_n),
    .enable      (enable),
`ifdef CLKDIV_SYNC_EN
    .syncRestart (sync),
`endif
    .cfg         (cfg_if.slave),
    .slowClock   (slowClock),
    .tick        (tick),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks channel ch for n samples from period position k0, ratio r; leaves the
  // bench on the sample after the last one checked.
  task automatic run_ch(input int ch, input int r, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      chk($sformatf("tick ch%0d R=%0d k=%0d", ch, r, k), 32'(tick[ch]), 32'((k % r) == 0));
      chk($sformatf("slow ch%0d R=%0d k=%0d", ch, r, k), 32'(slowClock[ch]), 32'((k % r) < ((r + 1) / 2)));
      step();
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [RW-1:0] ratio);
    cfg_if.cfgValid   = 1'b1;
    cfg_if.cfgChannel = ch;
    cfg_if.cfgRatio   = ratio;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    enable = '0;
    sync   = 1'b0;
    cfg_if.cfgValid   = 1'b0;
    cfg_if.cfgChannel = '0;
    cfg_if.cfgRatio   = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset slow", 32'(slowClock), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset pending", 32'(pending), 32'd0);
    chk("reset ready", 32'(cfg_if.cfgReady), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Ch0 at reset ratio: first tick one edge after enable, 50/50 duty
    enable = 3'b001;
    step();
    chk("ch0 first tick", 32'(tick[0]), 32'd1);
    run_ch(0, 100, 0, 230);

    // Ch0 write R=10 at count 30; a second write (R=7) waits for the wrap
    cfg_write(2'd0, 16'd10);
    #1 chk("ch0 ready before write", 32'(cfg_if.cfgReady), 32'd1);
    step();
    chk("ch0 pending after write", 32'(pending), 32'b001);
    cfg_if.cfgRatio = 16'd7;
    #1 chk("ch0 ready held off", 32'(cfg_if.cfgReady), 32'd0);
    for (int n = 231; n < 300; n++) begin
      chk($sformatf("ch0 no tick n=%0d", n), 32'(tick[0]), 32'd0);
      chk($sformatf("ch0 ready low n=%0d", n), 32'(cfg_if.cfgReady), 32'd0);
      step();
    end
    chk("ch0 wrap tick", 32'(tick[0]), 32'd1);
    chk("ch0 pending cleared", 32'(pending), 32'd0);
    chk("ch0 ready after wrap", 32'(cfg_if.cfgReady), 32'd1);
    step();
    chk("ch0 second write pending", 32'(pending), 32'b001);
    cfg_if.cfgValid = 1'b0;
    run_ch(0, 10, 1, 9);
    chk("ch0 R=7 applied", 32'(pending), 32'd0);
    run_ch(0, 7, 0, 14);
    enable = 3'b000;
    step();
    chk("ch0 disabled slow", 32'(slowClock[0]), 32'd0);
    chk("ch0 disabled tick", 32'(tick[0]), 32'd0);

    // Ch1 R=3 written while idle, then enabled
    cfg_write(2'd1, 16'd3);
    step();
    chk("ch1 pending idle", 32'(pending), 32'b010);
    cfg_if.cfgValid = 1'b0;
    step();
    chk("ch1 applied idle", 32'(pending), 32'd0);
    enable = 3'b010;
    step();
    run_ch(1, 3, 0, 8);

    // Write R=1 landing on a wrap edge: stored, applied at the following wrap
    cfg_write(2'd1, 16'd1);
    step();
    chk("ch1 tick on accept wrap", 32'(tick[1]), 32'd1);
    chk("ch1 pending on accept wrap", 32'(pending), 32'b010);
    cfg_if.cfgValid = 1'b0;
    step();
    chk("ch1 old R count1 slow", 32'(slowClock[1]), 32'd1);
    chk("ch1 old R count1 tick", 32'(tick[1]), 32'd0);
    step();
    chk("ch1 old R count2 slow", 32'(slowClock[1]), 32'd0);
    step();
    chk("ch1 R=1 applied", 32'(pending), 32'd0);
    run_ch(1, 1, 0, 5);
    enable = 3'b000;
    step();

    // Ch2 R=0 while running: period completes, then idle
    enable = 3'b100;
    step();
    run_ch(2, 100, 0, 20);
    cfg_write(2'd2, 16'd0);
    step();
    chk("ch2 pending zero ratio", 32'(pending), 32'b100);
    cfg_if.cfgValid = 1'b0;
    run_ch(2, 100, 21, 79);
    chk("ch2 idle after R=0 slow", 32'(slowClock[2]), 32'd0);
    chk("ch2 idle after R=0 tick", 32'(tick[2]), 32'd0);
    chk("ch2 R=0 applied", 32'(pending), 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("ch2 stays idle slow", 32'(slowClock[2]), 32'd0);
    chk("ch2 stays idle tick", 32'(tick[2]), 32'd0);

    // R=4 while idle: applied next edge, tick one edge later
    cfg_write(2'd2, 16'd4);
    step();
    chk("ch2 R=4 pending", 32'(pending), 32'b100);
    chk("ch2 no tick at accept", 32'(tick[2]), 32'd0);
    cfg_if.cfgValid = 1'b0;
    step();
    chk("ch2 R=4 applied", 32'(pending), 32'd0);
    chk("ch2 no tick at apply", 32'(tick[2]), 32'd0);
    step();
    run_ch(2, 4, 0, 8);

    // Async reset mid-period with a pending write
    cfg_write(2'd2, 16'd9);
    step();
    chk("ch2 pending before reset", 32'(pending), 32'b100);
    chk("ch2 slow before reset", 32'(slowClock[2]), 32'd1);
    cfg_if.cfgValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset slow", 32'(slowClock), 32'd0);
    chk("async reset tick", 32'(tick), 32'd0);
    chk("async reset pending", 32'(pending), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Out-of-range channel write is dropped; ch2 restarts at RESET_RATIO
    cfg_write(2'd3, 16'd5);
    #1 chk("out-of-range ready", 32'(cfg_if.cfgReady), 32'd1);
    chk("ch2 restart tick", 32'(tick[2]), 32'd1);
    step();
    chk("out-of-range no pending", 32'(pending), 32'd0);
    cfg_if.cfgValid = 1'b0;
    run_ch(2, 100, 1, 100);

`ifdef CLKDIV_SYNC_EN
    // syncRestart phase-aligns ch0 (R=6) and ch1 (R=9)
    enable = 3'b000;
    cfg_write(2'd0, 16'd6);
    step();
    cfg_write(2'd1, 16'd9);
    step();
    cfg_if.cfgValid = 1'b0;
    step();
    chk("sync ratios applied", 32'(pending), 32'd0);
    enable = 3'b001;
    step();
    step();
    enable = 3'b011;
    for (int i = 0; i < 3; i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync tick both", 32'(tick[1:0]), 32'b11);
    chk("sync slow both", 32'(slowClock[1:0]), 32'b11);
    step();
    chk("sync next tick clear", 32'(tick[1:0]), 32'b00);
    chk("sync next slow high", 32'(slowClock[1:0]), 32'b11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
